// File: rtl/cia_icr.sv
// CIA interrupt control register: sticky source flags, interrupt mask, and the IR/IRQ output,
// with either 6526 (one PHI2 delayed) or 8521 (same PHI2) interrupt timing.
module cia_icr #(
  parameter int unsigned MODEL = 0
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       phi2_up,
  input  logic       phi2_dn,
  input  logic       rd,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] data,
  input  logic       ta_int,
  input  logic       tb_int,
  input  logic       tod_int,
  input  logic       sp_int,
  input  logic       flag_int,
  output logic [7:0] regs,
  output logic       irq_n
);

  localparam int unsigned NSRC = 5;
  localparam logic [3:0]  ICR_ADDR = 4'hD;

  logic [NSRC-1:0] flags_q, flags_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic            ir_q, ir_d;
  logic            dly_q, dly_d;
  logic            tod_q, tod_d;
  logic            irq_n_q, irq_n_d;
  logic            icr_sel;
  logic            read_clr;
  logic            wr_icr;
  logic            pending;
  logic [NSRC-1:0] src;
  logic            unused_c;

  // phi2_up and the don't-care data bits carry no function here
  assign unused_c = ^{phi2_up, data[6:5]};

  assign icr_sel  = (addr == ICR_ADDR);
  assign read_clr = phi2_dn && rd && icr_sel;
  assign wr_icr   = phi2_dn && we && icr_sel;
  assign src      = {flag_int, sp_int, tod_int & ~tod_q, tb_int, ta_int};

  always_comb begin
    flags_d = flags_q;
    mask_d  = mask_q;
    ir_d    = ir_q;
    dly_d   = dly_q;
    tod_d   = tod_q;
    pending = 1'b0;
    if (phi2_dn) begin
      // new events beat the read-clear so they are never lost
      flags_d = (read_clr ? '0 : flags_q) | src;
      if (wr_icr) begin
        mask_d = data[7] ? (mask_q | data[NSRC-1:0]) : (mask_q & ~data[NSRC-1:0]);
      end
      pending = |(flags_d & mask_d);
      tod_d   = tod_int;
      if (MODEL == 1) begin
        ir_d  = (!read_clr && ir_q) || pending;
        dly_d = 1'b0;
      end else begin
        // delayed pending is dropped when it meets a read-clear; it re-arms from live pending
        ir_d  = !read_clr && (ir_q || dly_q);
        dly_d = pending;
      end
    end
    irq_n_d = ~ir_d;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      flags_q <= '0;
      mask_q  <= '0;
      ir_q    <= 1'b0;
      dly_q   <= 1'b0;
      tod_q   <= 1'b0;
      irq_n_q <= 1'b1;
    end else begin
      flags_q <= flags_d;
      mask_q  <= mask_d;
      ir_q    <= ir_d;
      dly_q   <= dly_d;
      tod_q   <= tod_d;
      irq_n_q <= irq_n_d;
    end
  end

  assign regs  = (rd && icr_sel) ? {ir_q, 2'b00, flags_q} : 8'h00;
  assign irq_n = irq_n_q;

endmodule
